// File: rtl/m_ttime_pkg.sv
// Shared types and constants for the ttime (mcycle) accumulator.
package m_ttime_pkg;
  typedef enum logic {IDLE = 1'b0, CARRY = 1'b1} state_t;

  localparam int TTIME_W = 64;
  localparam int HALF_W  = 32;
  localparam int CCNT_W  = 6;

  localparam logic [TTIME_W-1:0] CMP_RESET = '1;
endpackage

// File: rtl/m_ttime_cmp.sv
// mtimecmp register and registered ttime >= mtimecmp timer interrupt.
module m_ttime_cmp
  import m_ttime_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               eval_en,
  input  logic [TTIME_W-1:0] ttime,
  input  logic               cmp_we,
  input  logic               cmp_hi,
  input  logic [HALF_W-1:0]  cmp_wdata,
  output logic               irq
);
  logic [TTIME_W-1:0] mtimecmp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtimecmp <= CMP_RESET;
    end else if (cmp_we) begin
      if (cmp_hi) mtimecmp[TTIME_W-1:HALF_W] <= cmp_wdata;
      else        mtimecmp[HALF_W-1:0]       <= cmp_wdata;
    end
  end

  // Only sampled when both ttime halves are coherent; holds through the carry cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          irq <= 1'b0;
    else if (eval_en) irq <= (ttime >= mtimecmp);
  end
endmodule

// File: rtl/m_ttime_acc.sv
// 64-bit ttime accumulator: low-word add, then a separate carry cycle for the high word.
// Optional timer compare enabled by defining M_TTIME_CMP_EN.
module m_ttime_acc
  import m_ttime_pkg::*;
#(
  parameter logic [HALF_W-1:0] RESET_HI = 32'h0,
  parameter logic [HALF_W-1:0] RESET_LO = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              corerunning,
  input  logic              retire,
  input  logic [CCNT_W-1:0] ccnt,
  output logic              acc_busy,
  input  logic              rd_req,
  input  logic              rd_hi,
  output logic [HALF_W-1:0] rd_data,
  output logic              rd_ack,
  input  logic              cmp_we,
  input  logic              cmp_hi,
  input  logic [HALF_W-1:0] cmp_wdata,
  output logic              irq_timer
);
  state_t              state, state_nxt;
  logic [HALF_W-1:0]   lo, hi, shadow;
  logic                pend_vld;
  logic [CCNT_W-1:0]   pend_ccnt;
  logic                rd_hold, rd_hold_hi;
  logic                add_en, pend_set, rd_go, rd_sel_hi;
  logic [CCNT_W-1:0]   add_amt;
  logic [HALF_W:0]     lo_sum;

  // A retire parked during CARRY takes priority on the next IDLE cycle.
  assign add_amt = pend_vld ? pend_ccnt : ccnt;
  assign lo_sum  = {1'b0, lo} + {{(HALF_W+1-CCNT_W){1'b0}}, add_amt};

  always_comb begin
    state_nxt = state;
    add_en    = 1'b0;
    pend_set  = 1'b0;
    case (state)
      IDLE: begin
        add_en = pend_vld | (retire & corerunning);
        if (add_en && lo_sum[HALF_W]) state_nxt = CARRY;
      end
      CARRY: begin
        state_nxt = IDLE;
        pend_set  = retire & corerunning;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      lo    <= RESET_LO;
      hi    <= RESET_HI;
    end else begin
      state <= state_nxt;
      if (add_en)         lo <= lo_sum[HALF_W-1:0];
      if (state == CARRY) hi <= hi + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld  <= 1'b0;
      pend_ccnt <= '0;
    end else if (pend_set) begin
      pend_vld  <= 1'b1;
      pend_ccnt <= ccnt;
    end else if (state == IDLE) begin
      pend_vld  <= 1'b0;
    end
  end

  assign acc_busy = (state == CARRY) | pend_vld;

  // Reads are only served in IDLE so lo and hi are coherent when the shadow is taken.
  assign rd_go     = (state == IDLE) & (rd_req | rd_hold);
  assign rd_sel_hi = rd_hold ? rd_hold_hi : rd_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ack     <= 1'b0;
      rd_data    <= '0;
      shadow     <= '0;
      rd_hold    <= 1'b0;
      rd_hold_hi <= 1'b0;
    end else begin
      rd_ack  <= rd_go;
      rd_hold <= (state == CARRY) & rd_req;
      if (state == CARRY && rd_req) rd_hold_hi <= rd_hi;
      if (rd_go) begin
        if (rd_sel_hi) begin
          rd_data <= shadow;
        end else begin
          rd_data <= lo;
          shadow  <= hi;
        end
      end
    end
  end

`ifdef M_TTIME_CMP_EN
  logic eval_en;
  assign eval_en = (state == IDLE);

  m_ttime_cmp u_cmp (
    .clk      (clk),
    .rst      (rst),
    .eval_en  (eval_en),
    .ttime    ({hi, lo}),
    .cmp_we   (cmp_we),
    .cmp_hi   (cmp_hi),
    .cmp_wdata(cmp_wdata),
    .irq      (irq_timer)
  );
`else
  logic unused_cmp;
  assign unused_cmp = ^{cmp_we, cmp_hi, cmp_wdata};
  assign irq_timer  = 1'b0;
`endif
endmodule

// File: tb/tb_m_ttime_acc.sv
// Randomized + directed bench for m_ttime_acc: three instances with different reset values
// share stimulus and are checked every cycle against a 64-bit arithmetic reference model.
module tb_m_ttime_acc;
  localparam int N = 3;
  localparam logic [63:0] RV0 = 64'h0;
  localparam logic [63:0] RV1 = 64'h0000_0000_FFFF_FFF0;
  localparam logic [63:0] RV2 = 64'hFFFF_FFFF_FFFF_FFC0;

  logic        clk = 1'b0;
  logic        rst, corerunning, retire, rd_req, rd_hi, cmp_we, cmp_hi;
  logic [5:0]  ccnt;
  logic [31:0] cmp_wdata;
  logic        acc_busy [N];
  logic [31:0] rd_data  [N];
  logic        rd_ack   [N];
  logic        irq_timer[N];

  always #5 clk = ~clk;

  m_ttime_acc #(.RESET_HI(RV0[63:32]), .RESET_LO(RV0[31:0])) u_dut0 (
    .clk(clk), .rst(rst), .corerunning(corerunning), .retire(retire), .ccnt(ccnt),
    .acc_busy(acc_busy[0]), .rd_req(rd_req), .rd_hi(rd_hi), .rd_data(rd_data[0]),
    .rd_ack(rd_ack[0]), .cmp_we(cmp_we), .cmp_hi(cmp_hi), .cmp_wdata(cmp_wdata),
    .irq_timer(irq_timer[0]));
  m_ttime_acc #(.RESET_HI(RV1[63:32]), .RESET_LO(RV1[31:0])) u_dut1 (
    .clk(clk), .rst(rst), .corerunning(corerunning), .retire(retire), .ccnt(ccnt),
    .acc_busy(acc_busy[1]), .rd_req(rd_req), .rd_hi(rd_hi), .rd_data(rd_data[1]),
    .rd_ack(rd_ack[1]), .cmp_we(cmp_we), .cmp_hi(cmp_hi), .cmp_wdata(cmp_wdata),
    .irq_timer(irq_timer[1]));
  m_ttime_acc #(.RESET_HI(RV2[63:32]), .RESET_LO(RV2[31:0])) u_dut2 (
    .clk(clk), .rst(rst), .corerunning(corerunning), .retire(retire), .ccnt(ccnt),
    .acc_busy(acc_busy[2]), .rd_req(rd_req), .rd_hi(rd_hi), .rd_data(rd_data[2]),
    .rd_ack(rd_ack[2]), .cmp_we(cmp_we), .cmp_hi(cmp_hi), .cmp_wdata(cmp_wdata),
    .irq_timer(irq_timer[2]));

  // Reference model: full 64-bit ttime plus "hi update still owed" and queued-retire flags.
  logic [63:0] m_t     [N];
  bit          m_carry [N];
  bit          m_pv    [N];
  logic [5:0]  m_pc    [N];
  bit          m_dfr   [N];
  bit          m_dfr_hi[N];
  bit          m_ack   [N];
  bit          m_out   [N];
  bit          m_irq   [N];
  logic [31:0] m_shadow[N];
  logic [31:0] m_data  [N];
`ifdef M_TTIME_CMP_EN
  logic [63:0] m_cmp   [N];
`endif

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset(input int i);
    m_t[i]      = (i == 0) ? RV0 : (i == 1) ? RV1 : RV2;
    m_carry[i]  = 0; m_pv[i] = 0; m_pc[i] = '0;
    m_dfr[i]    = 0; m_dfr_hi[i] = 0; m_ack[i] = 0; m_out[i] = 0; m_irq[i] = 0;
    m_shadow[i] = '0; m_data[i] = '0;
`ifdef M_TTIME_CMP_EN
    m_cmp[i]    = '1;
`endif
  endtask

  task automatic model_step(input int i);
    bit          ack_n, have, h;
    logic [63:0] amt;
    ack_n = 0; have = 0; amt = '0;
    if (m_carry[i]) begin
      // high half is being settled this cycle: reads and retires are deferred
      if (rd_req) begin m_dfr[i] = 1; m_dfr_hi[i] = rd_hi; end
      if (retire && corerunning) begin
        assert (!m_pv[i]) else $error("retire while queued retire still pending");
        m_pv[i] = 1; m_pc[i] = ccnt;
      end
      m_carry[i] = 0;
    end else begin
`ifdef M_TTIME_CMP_EN
      m_irq[i] = (m_t[i] >= m_cmp[i]);
`endif
      if (rd_req || m_dfr[i]) begin
        h = m_dfr[i] ? m_dfr_hi[i] : rd_hi;
        ack_n = 1;
        if (h) m_data[i] = m_shadow[i];
        else begin m_data[i] = m_t[i][31:0]; m_shadow[i] = m_t[i][63:32]; end
        m_dfr[i] = 0;
      end
      if (m_pv[i]) begin have = 1; amt = 64'(m_pc[i]); m_pv[i] = 0; end
      else if (retire && corerunning) begin have = 1; amt = 64'(ccnt); end
      if (have) begin
        m_carry[i] = ((64'(m_t[i][31:0]) + amt) > 64'hFFFF_FFFF);
        m_t[i]     = m_t[i] + amt;
      end
    end
`ifdef M_TTIME_CMP_EN
    if (cmp_we) begin
      if (cmp_hi) m_cmp[i][63:32] = cmp_wdata;
      else        m_cmp[i][31:0]  = cmp_wdata;
    end
`endif
    m_ack[i] = ack_n;
    if (rd_req) m_out[i] = 1;
    if (ack_n)  m_out[i] = 0;
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (rst) model_reset(i);
      else     model_step(i);
    end
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("busy%0d", i), 64'(acc_busy[i]), 64'(m_carry[i] | m_pv[i]));
      chk($sformatf("ack%0d", i), 64'(rd_ack[i]), 64'(m_ack[i]));
      if (m_ack[i]) chk($sformatf("data%0d", i), 64'(rd_data[i]), 64'(m_data[i]));
      chk($sformatf("irq%0d", i), 64'(irq_timer[i]), 64'(m_irq[i]));
    end
    retire = 0; rd_req = 0; cmp_we = 0;
  endtask

  function automatic bit rd_free();
    bit f = 1;
    for (int i = 0; i < N; i++) if (m_out[i] || m_ack[i]) f = 0;
    return f;
  endfunction

  task automatic do_read(input bit hi);
    rd_req = 1; rd_hi = hi;
    step();
    for (int k = 0; k < 8 && !rd_free(); k++) step();
  endtask

  task automatic reset_dut();
    rst = 1; step(); step();
    rst = 0; step();
  endtask

  int gap;

  initial begin
    rst = 1; corerunning = 1; retire = 0; ccnt = '0; rd_req = 0; rd_hi = 0;
    cmp_we = 0; cmp_hi = 0; cmp_wdata = '0;
    step(); step();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_busy%0d", i), 64'(acc_busy[i]), 64'd0);
      chk($sformatf("rst_ack%0d", i), 64'(rd_ack[i]), 64'd0);
      chk($sformatf("rst_data%0d", i), 64'(rd_data[i]), 64'd0);
      chk($sformatf("rst_irq%0d", i), 64'(irq_timer[i]), 64'd0);
    end
    rst = 0; step();

    // ten retires of 5, three cycles apart
    for (int k = 0; k < 10; k++) begin ccnt = 6'd5; retire = 1; step(); step(); step(); end
    do_read(0); chk("t1_lo", 64'(rd_data[0]), 64'd50);
    do_read(1); chk("t1_hi", 64'(rd_data[0]), 64'd0);

    // retire ignored while core halted
    corerunning = 0; ccnt = 6'd63; retire = 1; step(); step(); step(); corerunning = 1;
    do_read(0); chk("t5_lo", 64'(rd_data[0]), 64'd50);

    // low-word wrap: one carry cycle
    reset_dut();
    ccnt = 6'd20; retire = 1; step(); chk("t2_busy", 64'(acc_busy[1]), 64'd1);
    step(); chk("t2_busy_clr", 64'(acc_busy[1]), 64'd0);
    step();
    do_read(0); chk("t2_lo", 64'(rd_data[1]), 64'd4);
    do_read(1); chk("t2_hi", 64'(rd_data[1]), 64'd1);

    // retire landing in the carry cycle is queued, not lost
    reset_dut();
    ccnt = 6'd20; retire = 1; step();
    ccnt = 6'd7;  retire = 1; step(); step(); step();
    do_read(0); chk("t3_lo", 64'(rd_data[1]), 64'd11);
    do_read(1); chk("t3_hi", 64'(rd_data[1]), 64'd1);

    // read issued during carry is served one cycle late
    reset_dut();
    ccnt = 6'd20; retire = 1; step();
    rd_req = 1; rd_hi = 0; step(); chk("t4_ack_dly", 64'(rd_ack[1]), 64'd0);
    step(); chk("t4_ack", 64'(rd_ack[1]), 64'd1); chk("t4_lo", 64'(rd_data[1]), 64'd4);
    step();
    do_read(1); chk("t4_hi", 64'(rd_data[1]), 64'd1);

    // reset in the middle of a carry
    reset_dut();
    do_read(0);
    ccnt = 6'd20; retire = 1; step();
    rst = 1; #1;
    chk("t6_busy", 64'(acc_busy[1]), 64'd0);
    chk("t6_ack", 64'(rd_ack[1]), 64'd0);
    chk("t6_data", 64'(rd_data[1]), 64'd0);
    chk("t6_irq", 64'(irq_timer[1]), 64'd0);
    step(); rst = 0; step();
    do_read(1); chk("t6_hi", 64'(rd_data[1]), 64'd0);
    do_read(0); chk("t6_lo", 64'(rd_data[1]), 64'hFFFF_FFF0);

`ifdef M_TTIME_CMP_EN
    // mtimecmp = 100, two adds of 60 cross it, raising mtimecmp high word clears it
    reset_dut();
    cmp_we = 1; cmp_hi = 0; cmp_wdata = 32'd100; step();
    cmp_we = 1; cmp_hi = 1; cmp_wdata = 32'd0;   step(); step();
    chk("t7_irq0", 64'(irq_timer[0]), 64'd0);
    ccnt = 6'd60; retire = 1; step(); step(); step();
    chk("t7_irq60", 64'(irq_timer[0]), 64'd0);
    ccnt = 6'd60; retire = 1; step(); step();
    chk("t7_irq120", 64'(irq_timer[0]), 64'd1);
    cmp_we = 1; cmp_hi = 1; cmp_wdata = 32'd1; step(); step();
    chk("t7_clr", 64'(irq_timer[0]), 64'd0);
`endif

    // random traffic, periodically reset so the near-wrap instances keep carrying
    gap = 2;
    for (int it = 0; it < 600; it++) begin
      if (it % 40 == 0) begin reset_dut(); gap = 2; end
      if (gap >= 2 && $urandom_range(0, 2) == 0) begin
        retire = 1; ccnt = 6'($urandom_range(0, 63)); gap = 0;
      end else begin
        gap++;
      end
      corerunning = ($urandom_range(0, 7) != 0);
      if (rd_free() && $urandom_range(0, 3) == 0) begin
        rd_req = 1; rd_hi = 1'($urandom_range(0, 1));
      end
`ifdef M_TTIME_CMP_EN
      if ($urandom_range(0, 15) == 0) begin
        cmp_we = 1; cmp_hi = 1'($urandom_range(0, 1));
        cmp_wdata = cmp_hi ? 32'($urandom_range(0, 1)) : $urandom;
      end
`endif
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
